// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the multi-cycle ALU.
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIVU = 4'd11;
    localparam logic [3:0] ALU_REMU = 4'd12;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result valid-ready bus between control unit (master) and ALU (slave).
interface alu_mc_if #(parameter int MAX_SIZE = 32);
    logic                in_valid;
    logic                in_ready;
    logic [MAX_SIZE-1:0] in0;
    logic [MAX_SIZE-1:0] in1;
    logic [3:0]          ALU_op;
    logic                out_valid;
    logic                out_ready;
    logic [MAX_SIZE-1:0] result;
    logic                zero_flag;
    logic                ovf_flag;
    logic                illegal_op;
    modport master (
        output in_valid, in0, in1, ALU_op, out_ready,
        input  in_ready, out_valid, result, zero_flag, ovf_flag, illegal_op
    );
    modport slave (
        input  in_valid, in0, in1, ALU_op, out_ready,
        output in_ready, out_valid, result, zero_flag, ovf_flag, illegal_op
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add MUL and restoring DIVU/REMU.
// res is the value the final step produces, valid in the cycle done is high.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 32,
    localparam int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] res
);
    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [W-1:0]  acc_q, acc_d, q_q, q_d, b_q, b_d, acc_n, q_n, b_n;
    logic [W:0]    r_sh, r_sub;
    logic          ge;

    always_comb begin
        r_sh  = {acc_q, q_q[W-1]};
        r_sub = r_sh - {1'b0, b_q};
        ge    = r_sh >= {1'b0, b_q};
        // a zero divisor always "fits", which yields quotient all-ones and remainder = dividend
        acc_n = (op_q == ALU_MUL) ? acc_q + (q_q[0] ? b_q : '0) : (ge ? r_sub[W-1:0] : r_sh[W-1:0]);
        q_n   = (op_q == ALU_MUL) ? q_q >> 1 : {q_q[W-2:0], ge};
        b_n   = (op_q == ALU_MUL) ? b_q << 1 : b_q;
        done  = active_q && (cnt_q == CW'(W-1));
        res   = (op_q == ALU_DIVU) ? q_n : acc_n;
        active_d = start ? 1'b1 : active_q & ~done;
        cnt_d    = start ? '0 : (active_q ? cnt_q + 1'b1 : cnt_q);
        op_d     = start ? op : op_q;
        acc_d    = start ? '0 : (active_q ? acc_n : acc_q);
        q_d      = start ? a : (active_q ? q_n : q_q);
        b_d      = start ? b : (active_q ? b_n : b_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            op_q     <= ALU_MUL;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            b_q      <= b_d;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and registered result/flags.
// Define ALU_MULDIV_EN to build the iterative MUL/DIVU/REMU path; otherwise ops 10-12 are illegal.
module alu_mc
    import alu_pkg::*;
#(
    parameter int MAX_SIZE = 32,
    localparam int SH_W = $clog2(MAX_SIZE)
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    localparam int M = MAX_SIZE;
    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic          zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
    logic [M-1:0]  result_q, result_d, alu_res, a, b;
    logic [SH_W-1:0] sh;
    logic          accept, alu_ovf, illegal;
`ifdef ALU_MULDIV_EN
    logic          is_md, md_done;
    logic [M-1:0]  md_res;

    alu_muldiv_iter #(.W(M)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept & is_md),
        .op    (bus.ALU_op),
        .a     (bus.in0),
        .b     (bus.in1),
        .done  (md_done),
        .res   (md_res)
    );
`endif

    always_comb begin
        a       = bus.in0;
        b       = bus.in1;
        sh      = b[SH_W-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ALU_op)
            ALU_ADD:  begin
                alu_res = a + b;
                alu_ovf = (a[M-1] == b[M-1]) && (alu_res[M-1] != a[M-1]);
            end
            ALU_SUB:  begin
                alu_res = a - b;
                alu_ovf = (a[M-1] != b[M-1]) && (alu_res[M-1] != a[M-1]);
            end
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_SLT:  alu_res = M'($signed(a) < $signed(b));
            ALU_SLTU: alu_res = M'(a < b);
            ALU_SLL:  alu_res = a << sh;
            ALU_SRL:  alu_res = a >> sh;
            ALU_SRA:  alu_res = M'($signed(a) >>> sh);
            default:  alu_res = '0;
        endcase
`ifdef ALU_MULDIV_EN
        is_md   = bus.ALU_op inside {ALU_MUL, ALU_DIVU, ALU_REMU};
        illegal = bus.ALU_op > ALU_REMU;
`else
        illegal = bus.ALU_op > ALU_SRA;
`endif
    end

    always_comb begin
        accept      = bus.in_valid & in_ready_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                result_d    = illegal ? '0 : alu_res;
                ovf_d       = ~illegal & alu_ovf;
                ill_d       = illegal;
`ifdef ALU_MULDIV_EN
                // long ops keep the previous result and flags until the iterator finishes
                if (is_md) begin
                    state_d     = BUSY;
                    out_valid_d = 1'b0;
                    result_d    = result_q;
                    ovf_d       = ovf_q;
                    ill_d       = ill_q;
                end
`endif
            end
`ifdef ALU_MULDIV_EN
            BUSY: if (md_done) begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                result_d    = md_res;
                ovf_d       = 1'b0;
                ill_d       = 1'b0;
            end
`endif
            DONE: if (bus.out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        zero_d     = result_d == '0;
        in_ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.zero_flag  = zero_q;
    assign bus.ovf_flag   = ovf_q;
    assign bus.illegal_op = ill_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc; MUL/DIVU/REMU cases follow ALU_MULDIV_EN.
module tb_alu_mc;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.MAX_SIZE(32)) bus ();
    alu_mc #(.MAX_SIZE(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, output int lat);
        bus.ALU_op = op;
        bus.in0 = x;
        bus.in1 = y;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in0 = ~x;
        bus.in1 = ~y;
        bus.ALU_op = ALU_AND;
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.ALU_op = ALU_ADD;
        repeat (2) @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        vectors++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", bus.zero_flag); end
        vectors++; if (bus.ovf_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf_flag); end
        vectors++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", bus.illegal_op); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add_sub;
        int lat;
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, lat);
        vectors++; if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result: got %h want 80000000", bus.result); end
        vectors++; if (bus.ovf_flag !== 1'b1) begin errors++; $display("FAIL add_ovf_flag: got %b want 1", bus.ovf_flag); end
        vectors++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL add_ovf_zero: got %b want 0", bus.zero_flag); end
        vectors++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
        vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add_done_in_ready: got %b want 0", bus.in_ready); end
        consume();
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_idle_in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_idle_out_valid: got %b want 0", bus.out_valid); end
        issue(ALU_SUB, 32'd5, 32'd5, lat);
        vectors++; if (bus.result !== 32'h0) begin errors++; $display("FAIL sub_zero_result: got %h want 0", bus.result); end
        vectors++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL sub_zero_flag: got %b want 1", bus.zero_flag); end
        vectors++; if (bus.ovf_flag !== 1'b0) begin errors++; $display("FAIL sub_zero_ovf: got %b want 0", bus.ovf_flag); end
        vectors++; if (lat !== 1) begin errors++; $display("FAIL sub_back_to_back_latency: got %0d want 1", lat); end
        consume();
        issue(ALU_SUB, 32'h8000_0000, 32'h1, lat);
        vectors++; if (bus.result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_ovf_result: got %h want 7fffffff", bus.result); end
        vectors++; if (bus.ovf_flag !== 1'b1) begin errors++; $display("FAIL sub_ovf_flag: got %b want 1", bus.ovf_flag); end
        consume();
    endtask

    task automatic test_single_cycle_ops;
        logic [3:0]  ops [13] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLT, ALU_SLTU,
                                   ALU_SRA, ALU_SLL, ALU_SRL, ALU_SRL, ALU_SRA, ALU_ADD};
        logic [31:0] xs [13] = '{32'hF0F0_1234, 32'h0F0F_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h1, 32'h1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'hF000_0000,
                                 32'h7000_0000, 32'hFFFF_FFFF};
        logic [31:0] ys [13] = '{32'h0FF0_FFFF, 32'h0000_F0F0, 32'hFF00_FF00, 32'h1, 32'h1,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd31, 32'h21, 32'h0, 32'd4,
                                 32'd4, 32'h1};
        logic [31:0] es [13] = '{32'h00F0_1234, 32'h0F0F_F0F0, 32'h00FF_FF00, 32'h1, 32'h0,
                                 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h2, 32'h8000_0000, 32'h0F00_0000,
                                 32'h0700_0000, 32'h0};
        int lat;
        for (int i = 0; i < 13; i++) begin
            issue(ops[i], xs[i], ys[i], lat);
            vectors++; if (bus.result !== es[i]) begin errors++; $display("FAIL op%0d_vec%0d_result: got %h want %h", ops[i], i, bus.result, es[i]); end
            vectors++; if (bus.zero_flag !== (es[i] == 32'h0)) begin errors++; $display("FAIL op%0d_vec%0d_zero: got %b want %b", ops[i], i, bus.zero_flag, es[i] == 32'h0); end
            vectors++; if ({bus.ovf_flag, bus.illegal_op} !== 2'b00) begin errors++; $display("FAIL op%0d_vec%0d_flags: got %b want 00", ops[i], i, {bus.ovf_flag, bus.illegal_op}); end
            vectors++; if (lat !== 1) begin errors++; $display("FAIL op%0d_vec%0d_latency: got %0d want 1", ops[i], i, lat); end
            consume();
        end
    endtask

    task automatic test_hold;
        int lat;
        issue(ALU_XOR, 32'h1234_5678, 32'hFFFF_FFFF, lat);
        bus.in_valid = 1'b1;
        bus.ALU_op = ALU_ADD;
        bus.in0 = 32'h1;
        bus.in1 = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (bus.result !== 32'hEDCB_A987) begin errors++; $display("FAIL hold%0d_result: got %h want edcba987", i, bus.result); end
            vectors++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL hold%0d_handshake: got %b want 10", i, {bus.out_valid, bus.in_ready}); end
        end
        bus.in_valid = 1'b0;
        consume();
        vectors++; if (bus.result !== 32'hEDCB_A987) begin errors++; $display("FAIL hold_after_consume: got %h want edcba987", bus.result); end
    endtask

    task automatic test_illegal;
`ifdef ALU_MULDIV_EN
        logic [3:0] ops [3] = '{4'd13, 4'd14, 4'd15};
`else
        logic [3:0] ops [3] = '{4'd10, 4'd12, 4'd15};
`endif
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 32'h0000_00FF, 32'h3, lat);
            vectors++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_op%0d_flag: got %b want 1", ops[i], bus.illegal_op); end
            vectors++; if (bus.result !== 32'h0) begin errors++; $display("FAIL illegal_op%0d_result: got %h want 0", ops[i], bus.result); end
            vectors++; if ({bus.zero_flag, bus.ovf_flag} !== 2'b10) begin errors++; $display("FAIL illegal_op%0d_zero_ovf: got %b want 10", ops[i], {bus.zero_flag, bus.ovf_flag}); end
            vectors++; if (lat !== 1) begin errors++; $display("FAIL illegal_op%0d_latency: got %0d want 1", ops[i], lat); end
            consume();
        end
        issue(ALU_ADD, 32'd2, 32'd3, lat);
        vectors++; if ({bus.illegal_op, bus.result} !== {1'b0, 32'd5}) begin errors++; $display("FAIL illegal_clear: got %b/%h want 0/00000005", bus.illegal_op, bus.result); end
        consume();
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv;
        logic [3:0]  ops [7] = '{ALU_MUL, ALU_MUL, ALU_DIVU, ALU_REMU, ALU_DIVU, ALU_REMU, ALU_DIVU};
        logic [31:0] xs [7] = '{32'h0001_0000, 32'd12345, 32'd7, 32'd7, 32'd100, 32'hFFFF_FFFF, 32'd100};
        logic [31:0] ys [7] = '{32'h0001_0000, 32'd6789, 32'd0, 32'd0, 32'd7, 32'd16, 32'd7};
        logic [31:0] es [7] = '{32'h0, 32'd83810205, 32'hFFFF_FFFF, 32'd7, 32'd14, 32'hF, 32'd14};
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], xs[i], ys[i], lat);
            vectors++; if (bus.result !== es[i]) begin errors++; $display("FAIL md_op%0d_vec%0d_result: got %h want %h", ops[i], i, bus.result, es[i]); end
            vectors++; if (lat !== 33) begin errors++; $display("FAIL md_op%0d_vec%0d_latency: got %0d want 33", ops[i], i, lat); end
            vectors++; if ({bus.zero_flag, bus.ovf_flag, bus.illegal_op} !== {es[i] == 32'h0, 2'b00}) begin errors++; $display("FAIL md_op%0d_vec%0d_flags: got %b want %b00", ops[i], i, {bus.zero_flag, bus.ovf_flag, bus.illegal_op}, es[i] == 32'h0); end
            consume();
        end
    endtask
`endif

    task automatic test_reset_mid_op;
        int seen = 0;
        bus.in_valid = 1'b1;
        bus.in0 = 32'd3;
        bus.in1 = 32'd5;
`ifdef ALU_MULDIV_EN
        bus.ALU_op = ALU_MUL;
`else
        bus.ALU_op = ALU_ADD;
`endif
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if ({bus.out_valid, bus.in_ready} !== 2'b00) begin errors++; $display("FAIL midreset_handshake: got %b want 00", {bus.out_valid, bus.in_ready}); end
        vectors++; if ({bus.result, bus.zero_flag} !== {32'h0, 1'b1}) begin errors++; $display("FAIL midreset_result: got %h/%b want 0/1", bus.result, bus.zero_flag); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_release_ready: got %b want 1", bus.in_ready); end
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        vectors++; if (seen !== 0) begin errors++; $display("FAIL midreset_discarded: got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_single_cycle_ops();
        test_hold();
        test_illegal();
`ifdef ALU_MULDIV_EN
        test_muldiv();
`endif
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
